// File: rtl/hpi_bus_master.sv
// hpi_bus_master: register-timed host-port master for an OTG controller.
// Turns a single-beat request into a chip-select / strobe sequence of
// programmable setup, strobe and hold lengths. Holds the OTG device in reset
// for RST_HOLD cycles after Reset releases.
// Optional build macro: HPI_INT_LATCH_EN turns the level irq into a sticky
// rising-edge interrupt cleared by irq_clr.
//
// Request handshake: req_ready is high only while the FSM is IDLE (and Reset
// is low). A transfer is accepted at a rising edge of Clk where req_valid and
// req_ready are both 1; req_valid is ignored at all other times and nothing is
// queued. Completion is signalled by a one-cycle rsp_valid pulse, during which
// req_ready is already high again so a new request can be accepted.
module hpi_bus_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RST_HOLD   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              irq_clr,
  output logic              irq,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_CS_N,
  output logic              OTG_RST_N,
  input  logic              OTG_INT
);

  localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B   = (HOLD_CYC > RST_HOLD) ? HOLD_CYC : RST_HOLD;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    RST_WAIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                xfer_wr_q, xfer_wr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                oe_q, oe_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                rst_n_q, rst_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                int_meta_q, int_meta_d;
  logic                int_sync_q, int_sync_d;

  assign req_ready = (state_q == IDLE) && !Reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign OTG_ADDR  = addr_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_RST_N = rst_n_q;
  assign OTG_DATA  = oe_q ? dout_q : {DATA_W{1'bz}};

  // Next-state, phase counting and registered OTG pin values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xfer_wr_d   = xfer_wr_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    addr_d      = addr_q;
    cs_n_d      = cs_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    rst_n_d     = rst_n_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      RST_WAIT: begin
        rst_n_d = 1'b0;
        if (int'(cnt_q) + 1 >= RST_HOLD) begin
          state_d = IDLE;
          cnt_d   = '0;
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (req_valid) begin
          state_d   = SETUP;
          cnt_d     = '0;
          cs_n_d    = 1'b0;
          addr_d    = req_addr;
          xfer_wr_d = req_write;
          dout_d    = req_wdata;
          oe_d      = req_write;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = STROBE;
          cnt_d   = '0;
          if (xfer_wr_q) wr_n_d = 1'b0;
          else           rd_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
          cnt_d  = '0;
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          // Read data is taken on the same edge that releases OTG_RD_N.
          if (!xfer_wr_q) rdata_d = OTG_DATA;
          if (HOLD_CYC == 0) begin
            state_d     = IDLE;
            cs_n_d      = 1'b1;
            oe_d        = 1'b0;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          cs_n_d      = 1'b1;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end

  // Two-flop synchronizer for the asynchronous device interrupt.
  always_comb begin
    int_meta_d = OTG_INT;
    int_sync_d = int_meta_q;
  end

  // State and pin registers; Reset forces the quiescent bus and device reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RST_WAIT;
      cnt_q       <= '0;
      xfer_wr_q   <= 1'b0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rst_n_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xfer_wr_q   <= xfer_wr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      rst_n_q     <= rst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      int_meta_q  <= int_meta_d;
      int_sync_q  <= int_sync_d;
    end
  end

`ifdef HPI_INT_LATCH_EN
  logic int_prev_q, int_prev_d;
  logic irq_q, irq_d;

  // Sticky interrupt: a synchronized rising edge sets it and beats irq_clr.
  always_comb begin
    int_prev_d = int_sync_q;
    irq_d      = irq_q;
    if (int_sync_q && !int_prev_q) irq_d = 1'b1;
    else if (irq_clr)              irq_d = 1'b0;
  end

  // Edge-detect history and interrupt latch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      int_prev_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      int_prev_q <= int_prev_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  // Level mode: irq follows the synchronized pin and irq_clr has no effect.
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = int_sync_q;
`endif

endmodule

// File: tb/tb_hpi_bus_master.sv
// tb_hpi_bus_master: directed and randomized bench for hpi_bus_master
// (default parameters). A transaction-level model tracks, from the accept
// edge onward, how many edges have elapsed and derives every pin from that
// offset; a compare process checks it after each rising edge.
module tb_hpi_bus_master;
  localparam int S  = 1;
  localparam int T  = 2;
  localparam int H  = 1;
  localparam int L  = S + T + H;
  localparam int RH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        Clk       = 1'b0;
  logic        Reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        irq_clr   = 1'b0;
  logic        OTG_INT   = 1'b0;
  logic [15:0] dev_data  = '0;

  wire         req_ready, rsp_valid, irq;
  wire  [15:0] rsp_rdata;
  wire  [15:0] otg_data;
  wire  [1:0]  otg_addr;
  wire         rd_n, wr_n, cs_n, rst_n;

  always #5 Clk = ~Clk;

  // Device side: drives the bus while it is selected and read-strobed.
  assign otg_data = (!cs_n && !rd_n) ? dev_data : 16'bz;

  hpi_bus_master dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .irq_clr   (irq_clr),
    .irq       (irq),
    .OTG_DATA  (otg_data),
    .OTG_ADDR  (otg_addr),
    .OTG_RD_N  (rd_n),
    .OTG_WR_N  (wr_n),
    .OTG_CS_N  (cs_n),
    .OTG_RST_N (rst_n),
    .OTG_INT   (OTG_INT)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_rel  = 0;
  int          m_k    = 0;
  bit          m_up   = 0;
  bit          m_busy = 0;
  bit          m_wr   = 0;
  bit          m_rv   = 0;
  bit          m_irq  = 0;
  logic [1:0]  m_addr_out = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  bit          s0 = 0, s1 = 0, s2 = 0, s3 = 0;
  logic [15:0] exp_q[$];

  // Model: everything follows from edges since reset release / since accept.
  always @(posedge Clk) begin
    if (Reset) begin
      m_up = 0; m_rel = 0; m_busy = 0; m_k = 0; m_rv = 0;
      m_rdata = '0; m_addr_out = '0; m_irq = 0;
      s0 = 0; s1 = 0; s2 = 0; s3 = 0;
      exp_q.delete();
    end else begin
      s3 = s2; s2 = s1; s1 = s0; s0 = OTG_INT;
`ifdef HPI_INT_LATCH_EN
      if (s2 && !s3)    m_irq = 1;
      else if (irq_clr) m_irq = 0;
`else
      m_irq = s1;
`endif
      m_rv = 0;
      if (!m_up) begin
        m_rel++;
        if (m_rel >= RH) m_up = 1;
      end else if (m_busy) begin
        m_k++;
        if (m_k == S + T && !m_wr) m_rdata = dev_data;
        if (m_k == L) begin
          m_busy = 0;
          m_rv   = 1;
          exp_q.push_back(m_rdata);
        end
      end else if (req_valid) begin
        m_busy = 1; m_k = 0;
        m_wr = req_write; m_wdata = req_wdata; m_addr_out = req_addr;
      end
    end
  end

  // Compare process: all outputs, 1 time unit after each rising edge.
  always @(posedge Clk) begin
    bit in_strobe;
    logic [15:0] got_rd;
    #1;
    in_strobe = m_busy && (m_k >= S) && (m_k < S + T);
    check("otg_cs_n",  cs_n,      !m_busy);
    check("otg_rd_n",  rd_n,      !(in_strobe && !m_wr));
    check("otg_wr_n",  wr_n,      !(in_strobe && m_wr));
    check("otg_rst_n", rst_n,     m_up);
    check("otg_addr",  otg_addr,  m_addr_out);
    check("req_ready", req_ready, m_up && !m_busy && !Reset);
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("irq",       irq,       m_irq);
    if (m_busy && m_wr) begin
      check("otg_data_write", otg_data, m_wdata);
    end else if (in_strobe) begin
      check("otg_data_read", otg_data, dev_data);
    end else begin
      checks++;
      if (!(otg_data === 16'bz || otg_data === 16'h0)) begin
        errors++;
        $display("FAIL otg_data_idle: got %0h expected z at %0t", otg_data, $time);
      end
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        got_rd = exp_q.pop_front();
        check("sb_rdata", rsp_rdata, got_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_xfer(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                         input logic [15:0] dd, output int cs_low, output int wr_low,
                         output int rd_low, output int rv_at, output logic [15:0] rd_val,
                         output int drv_cnt);
    int n;
    cs_low = 0; wr_low = 0; rd_low = 0; rv_at = -1; rd_val = '0; drv_cnt = 0;
    @(negedge Clk);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd; dev_data = dd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
      req_valid = 0;
      return;
    end
    for (int j = 0; j < 10; j++) begin
      @(posedge Clk); #1;
      if (!cs_n) cs_low++;
      if (!wr_n) wr_low++;
      if (!rd_n) rd_low++;
      if (wr && otg_data === wd) drv_cnt++;
      if (rsp_valid) begin
        rv_at  = j;
        rd_val = rsp_rdata;
      end
      if (j == 0) begin
        @(negedge Clk);
        req_valid = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cs_low, wr_low, rd_low, rv_at, drv_cnt, rst_low, first_rdy, n;
    int acc, rv_seen, first0, last0, gap;
    logic [15:0] rd_val;
    bit cs_hist[$];

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_rst_n", rst_n, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rdata", rsp_rdata, 0);

    // Reset release: 4 more low cycles, ready in the cycle after
    @(negedge Clk); Reset = 0;
    rst_low = 0; first_rdy = -1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge Clk); #1;
      if (!rst_n) rst_low++;
      if (req_ready && first_rdy < 0) first_rdy = j;
    end
    check("rel_rst_low_samples", rst_low, 3);
    check("rel_first_ready", first_rdy, 4);

    // Write addr 2, data A5C3
    do_xfer(1'b1, 2'd2, 16'hA5C3, 16'h0, cs_low, wr_low, rd_low, rv_at, rd_val, drv_cnt);
    check("wr_cs_low", cs_low, 4);
    check("wr_wr_low", wr_low, 2);
    check("wr_rd_low", rd_low, 0);
    check("wr_data_cycles", drv_cnt, 4);
    check("wr_rsp_at", rv_at, 4);

    // Read addr 1, device returns 1234
    do_xfer(1'b0, 2'd1, 16'h0, 16'h1234, cs_low, wr_low, rd_low, rv_at, rd_val, drv_cnt);
    check("rd_cs_low", cs_low, 4);
    check("rd_rd_low", rd_low, 2);
    check("rd_wr_low", wr_low, 0);
    check("rd_rsp_at", rv_at, 4);
    check("rd_rdata", rd_val, 16'h1234);

    // A write leaves the last read data in place
    do_xfer(1'b1, 2'd3, 16'h5A5A, 16'hFFFF, cs_low, wr_low, rd_low, rv_at, rd_val, drv_cnt);
    check("wr_keeps_rdata", rd_val, 16'h1234);

    // Back-to-back writes with req_valid held
    @(negedge Clk);
    req_valid = 1; req_write = 1; req_addr = 2'd3; req_wdata = 16'h0F0F;
    acc = 0; rv_seen = 0;
    for (int j = 0; j < 20; j++) begin
      if (req_valid && req_ready) acc++;
      @(posedge Clk); #1;
      cs_hist.push_back(cs_n);
      if (rsp_valid) rv_seen++;
      @(negedge Clk);
      if (acc >= 2)      req_valid = 0;
      else if (acc == 1) req_wdata = 16'h7E81;
    end
    first0 = -1; last0 = -1; gap = 0;
    foreach (cs_hist[i]) if (!cs_hist[i]) begin
      if (first0 < 0) first0 = i;
      last0 = i;
    end
    for (int i = first0; i <= last0 && first0 >= 0; i++) if (cs_hist[i]) gap++;
    check("b2b_cs_high_gap", gap, 1);
    check("b2b_responses", rv_seen, 2);

    // Reset during the first strobe cycle of a read
    @(negedge Clk);
    req_valid = 1; req_write = 0; req_addr = 2'd1; dev_data = 16'hBEEF;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("abort_ready", req_ready, 1);
    @(posedge Clk); #1;
    @(negedge Clk); req_valid = 0;
    @(posedge Clk); #1;
    check("abort_in_strobe", rd_n, 0);
    @(negedge Clk); Reset = 1;
    @(posedge Clk); #1;
    check("abort_rd_n", rd_n, 1);
    check("abort_cs_n", cs_n, 1);
    check("abort_rst_n", rst_n, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rdata", rsp_rdata, 0);
    @(negedge Clk); Reset = 0;
    repeat (8) @(negedge Clk);

    // Interrupt pulse
    OTG_INT = 1;
    @(posedge Clk); #1;
    check("irq_edge0", irq, 0);
    @(negedge Clk); OTG_INT = 0;
    @(posedge Clk); #1;
`ifdef HPI_INT_LATCH_EN
    check("irq_edge1", irq, 0);
    @(negedge Clk); irq_clr = 1;
    @(posedge Clk); #1;
    check("irq_set_beats_clr", irq, 1);
    @(negedge Clk); irq_clr = 0;
    @(posedge Clk); #1;
    check("irq_sticky", irq, 1);
    @(negedge Clk); irq_clr = 1;
    @(posedge Clk); #1;
    check("irq_cleared", irq, 0);
    @(negedge Clk); irq_clr = 0;
`else
    check("irq_edge1", irq, 1);
    @(posedge Clk); #1;
    check("irq_edge2", irq, 0);
`endif

    // Randomized traffic
    for (int c = 0; c < 700; c++) begin
      @(negedge Clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 2'($urandom_range(0, 3));
      req_wdata = 16'($urandom_range(0, 65535));
      dev_data  = 16'($urandom_range(0, 65535));
      OTG_INT   = ($urandom_range(0, 5) == 0);
      irq_clr   = ($urandom_range(0, 5) == 0);
      Reset     = ($urandom_range(0, 299) == 0);
    end
    @(negedge Clk);
    req_valid = 0; OTG_INT = 0; irq_clr = 0; Reset = 0;
    repeat (12) @(posedge Clk);
    #2;
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hpi_bus_master.md
HPI_BUS_MASTER -- requirements
Module: hpi_bus_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16: OTG data bus and request data width.
REQ-002 SHALL have parameter ADDR_W, default 2: OTG address width.
REQ-003 SHALL have parameter SETUP_CYC, default 1 (legal range >=1): cycles with CS_N low before the strobe.
REQ-004 SHALL have parameter STROBE_CYC, default 2 (legal range >=1): cycles with RD_N/WR_N low.
REQ-005 SHALL have parameter HOLD_CYC, default 1 (legal range >=0): cycles with CS_N low after the strobe.
REQ-006 SHALL have parameter RST_HOLD, default 4: cycles OTG_RST_N stays low after Reset deasserts.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- Clk  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  1  transfer request
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  last read data
- irq_clr  in  1  clears the latched interrupt
- irq  out  1  interrupt to software
- OTG_DATA  inout  DATA_W  tristate data bus
- OTG_ADDR  out  ADDR_W  address
- OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N  out  1 each  active-low strobes, chip select and reset
- OTG_INT  in  1  asynchronous device interrupt, active-high

Function
REQ-008 SHALL implement the FSM states RST_WAIT, IDLE, SETUP, STROBE and HOLD.
REQ-009 SHALL drive req_ready=1 only in IDLE; a transfer is accepted at an edge where req_valid and req_ready are both 1.
REQ-010 SHALL capture req_write, req_addr and req_wdata at the accept edge E0 and hold them until the transfer ends.
REQ-011 SHALL drive all OTG outputs from registers; at E0, OTG_CS_N falls and OTG_ADDR is driven.
REQ-012 SHALL stay in SETUP for SETUP_CYC cycles, then in STROBE for STROBE_CYC cycles, then in HOLD for HOLD_CYC cycles; when HOLD_CYC=0 the HOLD state is skipped.
REQ-013 SHALL hold OTG_RD_N (read) or OTG_WR_N (write) low only while in STROBE; the other strobe stays 1.
REQ-014 SHALL drive OTG_DATA with the captured wdata during SETUP, STROBE and HOLD of a write, and hold it at high impedance otherwise.
REQ-015 SHALL, for a read, sample OTG_DATA into rsp_rdata at edge E0+SETUP_CYC+STROBE_CYC, the same edge at which OTG_RD_N rises.
REQ-016 SHALL leave rsp_rdata unchanged on writes.
REQ-017 SHALL, at edge E0+SETUP_CYC+STROBE_CYC+HOLD_CYC, raise OTG_CS_N, return to IDLE and assert rsp_valid for exactly one cycle.
REQ-018 SHALL permit back-to-back transfers: a request seen during the rsp_valid cycle is accepted, giving exactly one cycle of OTG_CS_N high between transfers.
REQ-019 SHALL ignore req_valid outside IDLE, with no queueing of requests.
REQ-020 SHALL use phase counters of width $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC,RST_HOLD)+1); counters never wrap.

Reset
REQ-021 SHALL, while Reset=1, force state RST_WAIT, OTG_CS_N=OTG_RD_N=OTG_WR_N=1, OTG_RST_N=0, OTG_ADDR=0, OTG_DATA=Z, req_ready=0, rsp_valid=0, rsp_rdata=0 and irq=0, and clear the synchronizers.
REQ-022 SHALL keep OTG_RST_N low for RST_HOLD cycles after Reset deasserts, then raise OTG_RST_N and enter IDLE, so that req_ready=1 on the following cycle.
REQ-023 SHALL, if Reset asserts mid-transfer, abort at the next edge with all strobes and CS_N high, no rsp_valid, and rsp_rdata=0.

Configuration
REQ-024 SHALL pass OTG_INT through a two-flop synchronizer in all builds.
REQ-025 SHALL, with macro HPI_INT_LATCH_EN defined, set a sticky irq on a rising edge of the synchronized OTG_INT and clear it on irq_clr=1; set wins over a simultaneous clear.
REQ-026 SHALL, without HPI_INT_LATCH_EN, drive irq equal to the synchronized OTG_INT level and ignore irq_clr.

Verification
REQ-027 SHALL cover reset release with defaults: Reset 1->0 -> OTG_RST_N low 4 more cycles, then req_ready=1 on the following cycle.
REQ-028 SHALL cover a write with addr=2'd2, wdata=16'hA5C3 -> OTG_CS_N low 4 cycles, OTG_WR_N low in cycles 2-3, OTG_DATA=16'hA5C3 for all 4 cycles, rsp_valid at E0+4.
REQ-029 SHALL cover a read with addr=2'd1 while the device drives 16'h1234 -> OTG_RD_N low 2 cycles, rsp_rdata=16'h1234 when rsp_valid=1, OTG_DATA Z from the master throughout.
REQ-030 SHALL cover req_valid held high for two writes -> second accept in the rsp_valid cycle and OTG_CS_N high for exactly 1 cycle between transfers.
REQ-031 SHALL cover Reset asserted in the first STROBE cycle of a read -> next edge OTG_RD_N=OTG_CS_N=1 and OTG_RST_N=0, with no rsp_valid.
REQ-032 SHALL cover, with HPI_INT_LATCH_EN, a 1-cycle OTG_INT pulse -> irq=1 three edges later and held; irq_clr in the set cycle leaves irq=1; a later irq_clr gives irq=0. Without the macro -> irq=1 for 1 cycle, 2 edges later.
